// File: rtl/lsu_handshake.sv
// Load/store unit: IDLE -> REQ (req/ack with optional timeout) -> DONE. Start -> mem_req next cycle, ack -> done next cycle.
// The memory side stalls via mem_ack; start is only sampled in IDLE and is never queued.
module lsu_handshake #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                start,
  input  logic                is_store,
  input  logic                size,
  input  logic                ld_signed,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              lat_store;
  logic              lat_size;
  logic              lat_signed;
  logic [LANE_W-1:0] lat_lane;

  logic [LANE_W-1:0] lane;
  logic              misaligned;
  logic              timeout_hit;
  logic [7:0]        ld_byte;
  logic [DATA_W-1:0] ld_word;

  assign lane        = addr[LANE_W-1:0];
  assign misaligned  = size && (lane != '0);
  assign timeout_hit = (TIMEOUT > 0) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    ld_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (lat_lane == LANE_W'(i)) ld_byte = mem_rdata[i*8 +: 8];
    end
  end

  assign ld_word = lat_size ? mem_rdata
                            : {{(DATA_W-8){lat_signed & ld_byte[7]}}, ld_byte};

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      lat_store  <= 1'b0;
      lat_size   <= 1'b0;
      lat_signed <= 1'b0;
      lat_lane   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      rdata      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          err      <= 1'b0;
          err_code <= 2'b00;
          if (start) begin
            lat_store  <= is_store;
            lat_size   <= size;
            lat_signed <= ld_signed;
            lat_lane   <= lane;
            busy       <= 1'b1;
            if (misaligned) begin
              state    <= DONE;
              done     <= 1'b1;
              err      <= 1'b1;
              err_code <= 2'b01;
            end else begin
              state     <= REQ;
              tmo_cnt   <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
              mem_be    <= size ? {NB{1'b1}} : ({{(NB-1){1'b0}}, 1'b1} << lane);
              mem_wdata <= size ? wdata : {NB{wdata[7:0]}};
            end
          end
        end
        REQ: begin
          // Ack has priority over a timeout expiring on the same edge.
          if (mem_ack || timeout_hit) begin
            state     <= DONE;
            done      <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if (mem_ack) begin
              if (!lat_store) rdata <= ld_word;
            end else begin
              err      <= 1'b1;
              err_code <= 2'b10;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          err      <= 1'b0;
          err_code <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_handshake.sv
// Scoreboard bench for lsu_handshake (DATA_W=16, ADDR_W=16, TIMEOUT=4).
module tb_lsu_handshake;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic        size = 1'b0;
  logic        ld_signed = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;

  always #5 clock = ~clock;

  lsu_handshake #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) dut (
    .clock(clock), .rst(rst), .start(start), .is_store(is_store), .size(size),
    .ld_signed(ld_signed), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .rdata(rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic       err;
    logic [1:0] code;
    logic [15:0] rdata;
    logic [7:0] req_cyc;
    logic [7:0] lat;
  } exp_t;

  typedef struct packed {
    logic        done_seen;
    logic        stable;
    logic [7:0]  req_cyc;
    logic [7:0]  lat;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        err;
    logic [1:0]  code;
    logic [15:0] rdata;
  } obs_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic [15:0] model_rdata = '0;

  // Drives one access, acks on REQ cycle ack_at (0 = never), records what the memory side saw.
  task automatic run_access(input logic st, input logic sz, input logic sg,
                            input logic [15:0] a, input logic [15:0] wd,
                            input int ack_at, input logic [15:0] mrd, output obs_t o);
    o = '0;
    o.stable = 1'b1;
    @(negedge clock);
    start = 1'b1; is_store = st; size = sz; ld_signed = sg; addr = a; wdata = wd;
    mem_rdata = mrd;
    @(negedge clock);
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      o.lat = 8'(i);
      if (mem_req) begin
        o.req_cyc = o.req_cyc + 8'd1;
        if (o.req_cyc == 8'd1) begin
          o.we = mem_we; o.addr = mem_addr; o.wdata = mem_wdata; o.be = mem_be;
        end else if (mem_we !== o.we || mem_addr !== o.addr ||
                     mem_wdata !== o.wdata || mem_be !== o.be) begin
          o.stable = 1'b0;
        end
        mem_ack = (int'(o.req_cyc) == ack_at);
      end else begin
        mem_ack = 1'b0;
      end
      if (done) begin
        o.done_seen = 1'b1; o.err = err; o.code = err_code; o.rdata = rdata;
        break;
      end
      @(negedge clock);
    end
    mem_ack = 1'b0;
  endtask

  // Reference byte/word load result from address lane and memory data.
  function automatic logic [15:0] ld_model(input logic sz, input logic sg,
                                          input logic [15:0] a, input logic [15:0] mrd);
    logic [7:0] b;
    if (sz) return mrd;
    b = a[0] ? mrd[15:8] : mrd[7:0];
    return {{8{sg & b[7]}}, b};
  endfunction

  task automatic test_reset();
    @(negedge clock);
    n_checks++;
    if ({busy, done, err, err_code, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b code=%b rdata=%h req=%b we=%b addr=%h wd=%h be=%b, want all 0",
               busy, done, err, err_code, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be);
    end
    rst = 1'b1;
  endtask

  task automatic test_full_store();
    obs_t o; exp_t e;
    q.push_back('{err: 1'b0, code: 2'b00, rdata: model_rdata, req_cyc: 8'd3, lat: 8'd4});
    run_access(1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 3, 16'h0000, o);
    e = q.pop_front();
    n_checks++;
    if ({o.done_seen, o.err, o.code, o.rdata, o.req_cyc, o.lat} !== {1'b1, e.err, e.code, e.rdata, e.req_cyc, e.lat}) begin
      n_fail++;
      $display("FAIL full_store_result: done=%b err=%b code=%b rdata=%h req=%0d lat=%0d, want done=1 err=%b code=%b rdata=%h req=%0d lat=%0d",
               o.done_seen, o.err, o.code, o.rdata, o.req_cyc, o.lat, e.err, e.code, e.rdata, e.req_cyc, e.lat);
    end
    n_checks++;
    if ({o.stable, o.we, o.addr, o.be, o.wdata} !== {1'b1, 1'b1, 16'h0010, 2'b11, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL full_store_bus: stable=%b we=%b addr=%h be=%b wdata=%h, want 1 1 0010 11 beef",
               o.stable, o.we, o.addr, o.be, o.wdata);
    end
  endtask

  task automatic test_byte_load();
    obs_t o; exp_t e;
    for (int s = 1; s >= 0; s--) begin
      model_rdata = ld_model(1'b0, s[0], 16'h0021, 16'h80FF);
      q.push_back('{err: 1'b0, code: 2'b00, rdata: model_rdata, req_cyc: 8'd1, lat: 8'd2});
      run_access(1'b0, 1'b0, s[0], 16'h0021, 16'h0000, 1, 16'h80FF, o);
      e = q.pop_front();
      n_checks++;
      if ({o.done_seen, o.err, o.code, o.rdata, o.req_cyc, o.lat} !== {1'b1, e.err, e.code, e.rdata, e.req_cyc, e.lat}) begin
        n_fail++;
        $display("FAIL byte_load_s%0d: done=%b err=%b code=%b rdata=%h req=%0d lat=%0d, want done=1 err=%b code=%b rdata=%h req=%0d lat=%0d",
                 s, o.done_seen, o.err, o.code, o.rdata, o.req_cyc, o.lat, e.err, e.code, e.rdata, e.req_cyc, e.lat);
      end
      n_checks++;
      if ({o.we, o.addr, o.be} !== {1'b0, 16'h0020, 2'b10}) begin
        n_fail++;
        $display("FAIL byte_load_bus_s%0d: we=%b addr=%h be=%b, want 0 0020 10", s, o.we, o.addr, o.be);
      end
    end
    // Lane 0 signed load with a short wait.
    model_rdata = ld_model(1'b0, 1'b1, 16'h0040, 16'h7F85);
    q.push_back('{err: 1'b0, code: 2'b00, rdata: model_rdata, req_cyc: 8'd2, lat: 8'd3});
    run_access(1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000, 2, 16'h7F85, o);
    e = q.pop_front();
    n_checks++;
    if ({o.rdata, o.be, o.req_cyc} !== {e.rdata, 2'b01, e.req_cyc}) begin
      n_fail++;
      $display("FAIL byte_load_lane0: rdata=%h be=%b req=%0d, want %h 01 %0d", o.rdata, o.be, o.req_cyc, e.rdata, e.req_cyc);
    end
  endtask

  task automatic test_byte_store();
    obs_t o; exp_t e;
    q.push_back('{err: 1'b0, code: 2'b00, rdata: model_rdata, req_cyc: 8'd1, lat: 8'd2});
    run_access(1'b1, 1'b0, 1'b0, 16'h0005, 16'h12A7, 1, 16'h0000, o);
    e = q.pop_front();
    n_checks++;
    if ({o.done_seen, o.err, o.rdata, o.req_cyc, o.lat} !== {1'b1, e.err, e.rdata, e.req_cyc, e.lat}) begin
      n_fail++;
      $display("FAIL byte_store_result: done=%b err=%b rdata=%h req=%0d lat=%0d, want 1 %b %h %0d %0d",
               o.done_seen, o.err, o.rdata, o.req_cyc, o.lat, e.err, e.rdata, e.req_cyc, e.lat);
    end
    n_checks++;
    if ({o.we, o.addr, o.be, o.wdata} !== {1'b1, 16'h0004, 2'b10, 16'hA7A7}) begin
      n_fail++;
      $display("FAIL byte_store_bus: we=%b addr=%h be=%b wdata=%h, want 1 0004 10 a7a7", o.we, o.addr, o.be, o.wdata);
    end
  endtask

  task automatic test_misaligned();
    obs_t o; exp_t e;
    q.push_back('{err: 1'b1, code: 2'b01, rdata: model_rdata, req_cyc: 8'd0, lat: 8'd1});
    run_access(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 1, 16'hFFFF, o);
    e = q.pop_front();
    n_checks++;
    if ({o.done_seen, o.err, o.code, o.rdata, o.req_cyc, o.lat} !== {1'b1, e.err, e.code, e.rdata, e.req_cyc, e.lat}) begin
      n_fail++;
      $display("FAIL misaligned: done=%b err=%b code=%b rdata=%h req=%0d lat=%0d, want done=1 err=%b code=%b rdata=%h req=%0d lat=%0d",
               o.done_seen, o.err, o.code, o.rdata, o.req_cyc, o.lat, e.err, e.code, e.rdata, e.req_cyc, e.lat);
    end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    q.push_back('{err: 1'b1, code: 2'b10, rdata: model_rdata, req_cyc: 8'd4, lat: 8'd5});
    run_access(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 0, 16'h5555, o);
    e = q.pop_front();
    n_checks++;
    if ({o.done_seen, o.err, o.code, o.rdata, o.req_cyc, o.lat} !== {1'b1, e.err, e.code, e.rdata, e.req_cyc, e.lat}) begin
      n_fail++;
      $display("FAIL timeout: done=%b err=%b code=%b rdata=%h req=%0d lat=%0d, want done=1 err=%b code=%b rdata=%h req=%0d lat=%0d",
               o.done_seen, o.err, o.code, o.rdata, o.req_cyc, o.lat, e.err, e.code, e.rdata, e.req_cyc, e.lat);
    end
    model_rdata = ld_model(1'b1, 1'b0, 16'h0030, 16'h1234);
    q.push_back('{err: 1'b0, code: 2'b00, rdata: model_rdata, req_cyc: 8'd4, lat: 8'd5});
    run_access(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 4, 16'h1234, o);
    e = q.pop_front();
    n_checks++;
    if ({o.done_seen, o.err, o.code, o.rdata, o.req_cyc, o.lat} !== {1'b1, e.err, e.code, e.rdata, e.req_cyc, e.lat}) begin
      n_fail++;
      $display("FAIL ack_on_last_cycle: done=%b err=%b code=%b rdata=%h req=%0d lat=%0d, want done=1 err=%b code=%b rdata=%h req=%0d lat=%0d",
               o.done_seen, o.err, o.code, o.rdata, o.req_cyc, o.lat, e.err, e.code, e.rdata, e.req_cyc, e.lat);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t e;
    @(negedge clock);
    start = 1'b1; is_store = 1'b1; size = 1'b1; addr = 16'h0050; wdata = 16'h9999;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    n_checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: mem_req=%b busy=%b, want 1 1", mem_req, busy);
    end
    rst = 1'b0;
    #1;
    model_rdata = '0;
    n_checks++;
    if ({mem_req, busy, done, rdata} !== {3'b000, model_rdata}) begin
      n_fail++;
      $display("FAIL reset_mid_drop: mem_req=%b busy=%b done=%b rdata=%h, want 0 0 0 0000", mem_req, busy, done, rdata);
    end
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: done=%b busy=%b, want 0 0", done, busy);
    end
    model_rdata = ld_model(1'b1, 1'b0, 16'h0060, 16'hC3C3);
    q.push_back('{err: 1'b0, code: 2'b00, rdata: model_rdata, req_cyc: 8'd2, lat: 8'd3});
    run_access(1'b0, 1'b1, 1'b0, 16'h0060, 16'h0000, 2, 16'hC3C3, o);
    e = q.pop_front();
    n_checks++;
    if ({o.done_seen, o.err, o.rdata, o.req_cyc, o.lat} !== {1'b1, e.err, e.rdata, e.req_cyc, e.lat}) begin
      n_fail++;
      $display("FAIL reset_mid_recover: done=%b err=%b rdata=%h req=%0d lat=%0d, want 1 %b %h %0d %0d",
               o.done_seen, o.err, o.rdata, o.req_cyc, o.lat, e.err, e.rdata, e.req_cyc, e.lat);
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    logic seen = 1'b0;
    int   reqs = 0;
    model_rdata = ld_model(1'b1, 1'b0, 16'h0070, 16'hA5A5);
    q.push_back('{err: 1'b0, code: 2'b00, rdata: model_rdata, req_cyc: 8'd2, lat: 8'd3});
    @(negedge clock);
    start = 1'b1; is_store = 1'b0; size = 1'b1; addr = 16'h0070; mem_rdata = 16'hA5A5;
    @(negedge clock);
    // Keep start high with a misaligned request through REQ and DONE.
    addr = 16'h0003; is_store = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) reqs++;
      mem_ack = mem_req && (reqs == 2);
      if (done) begin
        e = q.pop_front();
        seen = 1'b1;
        n_checks++;
        if ({err, err_code, rdata, 8'(reqs)} !== {e.err, e.code, e.rdata, e.req_cyc}) begin
          n_fail++;
          $display("FAIL ignore_start_result: err=%b code=%b rdata=%h req=%0d, want %b %b %h %0d",
                   err, err_code, rdata, reqs, e.err, e.code, e.rdata, e.req_cyc);
        end
        break;
      end
      @(negedge clock);
    end
    mem_ack = 1'b0;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL ignore_start_done: done=0 within bound, want 1");
    end
    @(negedge clock);
    start = 1'b0;
    mem_ack = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if ({busy, done, mem_req, rdata} !== {3'b000, model_rdata}) begin
      n_fail++;
      $display("FAIL ignore_start_not_queued: busy=%b done=%b mem_req=%b rdata=%h, want 0 0 0 %h",
               busy, done, mem_req, rdata, model_rdata);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_store();
    test_byte_load();
    test_byte_store();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_ignore_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
